offchip_mem_responder: RTL
==========================

OFFCHIP_MEM_RESPONDER -- requirements
Module: offchip_mem_responder

Interface
REQ-001 Parameter LINE_BYTES, default 32: cache-line size in bytes; SHALL be a power of two >= 4; WORDS = LINE_BYTES/4.
REQ-002 Parameter MEM_WORDS, default 4096: backing-store depth in 32-bit words; SHALL be a power of two.
REQ-003 Parameter LAT, default 4: access wait cycles before the transfer; range 0..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 offchip_mem_read_en  in  1  line-read request level, held by requester until ready.
REQ-007 offchip_mem_write_en  in  1  line-write request level, held by requester until ready.
REQ-008 offchip_mem_addr  in  32  byte address of the line; low log2(LINE_BYTES) bits ignored.
REQ-009 offchip_mem_wdata  in  LINE_BYTES*8  write line; word i at bits [32i+31:32i].
REQ-010 offchip_mem_data  out  LINE_BYTES*8  read line, same word packing.
REQ-011 offchip_mem_ready  out  1  one-cycle completion pulse.
REQ-012 offchip_mem_read_busy  out  1  read in progress.
REQ-013 offchip_mem_write_busy  out  1  write in progress.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, XFER, DONE, HOLD.
REQ-015 IDLE: write_en=1 -> accept write; else read_en=1 -> accept read; write wins on simultaneous assertion. Addr and wdata are latched at acceptance.
REQ-016 Acceptance SHALL go to WAIT when LAT>0, else directly to XFER.
REQ-017 WAIT SHALL last exactly LAT cycles (down-counter), then go to XFER.
REQ-018 XFER SHALL move one word per cycle for WORDS cycles, word 0 first; read: mem[base+i] -> data word i; write: latched word i -> mem[base+i].
REQ-019 base = line index * WORDS, modulo MEM_WORDS.
REQ-020 DONE SHALL last one cycle with offchip_mem_ready=1, then go to HOLD.
REQ-021 HOLD SHALL stay until read_en=0 and write_en=0 in the same cycle, then go to IDLE; a request is never served twice.
REQ-022 Latency: ready is high in the (1+LAT+WORDS)th cycle after the acceptance edge; defaults give 13.
REQ-023 read_busy/write_busy SHALL be 1 in WAIT and XFER for the accepted type only; 0 in IDLE, DONE, HOLD.
REQ-024 offchip_mem_data SHALL hold the last completed read line until the next read's XFER overwrites it; writes do not change it.
REQ-025 Request changes after acceptance (addr, wdata, enables) SHALL be ignored until HOLD exits.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, counters 0, ready=0, both busy=0, offchip_mem_data=0.
REQ-027 Backing memory SHALL NOT be reset; reset mid-write leaves already written words written and the rest unchanged.
REQ-028 Reset mid-operation SHALL produce no ready pulse for the aborted request.

Configuration
REQ-029 Macro OFFCHIP_MEM_RANGE_CHK_EN defined: extra output offchip_mem_err (1 bit, reset 0); a request whose line index >= MEM_WORDS/WORDS SHALL skip memory access, complete with the normal latency, return an all-zero read line, and pulse err together with ready.
REQ-030 Macro undefined: no err port; out-of-range addresses wrap modulo MEM_WORDS per REQ-019.

Verification
REQ-031 Defaults, write line 0x0000_0100 with words 0x11111111..0x88888888 -> write_busy 12 cycles, ready pulse at cycle 13, then enables dropped.
REQ-032 Read 0x0000_0100 after REQ-031 -> ready at cycle 13, data word i = 0x11111111*(i+1), read_busy never set during write.
REQ-033 read_en and write_en both asserted at 0x200 -> write performed, read not served; enables held through ready -> single ready pulse, FSM in HOLD until both low.
REQ-034 LAT=0, read -> ready at cycle 9 (1+8) after acceptance.
REQ-035 rst at XFER beat 3 of a write -> no ready, outputs 0 next cycle; subsequent read shows words 0-2 new, 3-7 old.
REQ-036 With OFFCHIP_MEM_RANGE_CHK_EN, read at line index 512 (MEM_WORDS=4096) -> ready and err together at cycle 13, data 0; without it, same read returns line 0 contents.

Source files
------------

// File: rtl/offchip_mem_responder.sv
// ---------------------------------------------------------------------------
// offchip_mem_responder
//
// Behavioural model of an off-chip line memory. It answers cache-line read and
// write requests after LAT wait cycles, then moves one 32-bit word per cycle
// for WORDS cycles. It pulses ready for one cycle and then waits for the
// requester to drop both enables before it accepts the next request.
//
// Parameters
//   LINE_BYTES : line size in bytes (power of two, >= 4); WORDS = LINE_BYTES/4
//   MEM_WORDS  : backing-store depth in 32-bit words (power of two)
//   LAT        : wait cycles before the transfer (0..15)
//
// Ports
//   clk                    : clock, rising edge
//   rst                    : synchronous active-high reset
//   offchip_mem_read_en    : line-read request level
//   offchip_mem_write_en   : line-write request level (wins over read)
//   offchip_mem_addr       : byte address of the line
//   offchip_mem_wdata      : write line, word i at [32i+31:32i]
//   offchip_mem_data       : last completed read line
//   offchip_mem_ready      : one-cycle completion pulse
//   offchip_mem_read_busy  : read in WAIT/XFER
//   offchip_mem_write_busy : write in WAIT/XFER
//   offchip_mem_err        : (OFFCHIP_MEM_RANGE_CHK_EN only) out-of-range
//                            request, pulses together with ready
//
// Build option
//   OFFCHIP_MEM_RANGE_CHK_EN : when defined, requests whose line index lies
//   beyond the backing store skip the memory access, return a zero line and
//   raise offchip_mem_err. When undefined, such addresses wrap.
//
// State | meaning
// IDLE  | waiting for a request
// WAIT  | access latency, LAT cycles on a down-counter
// XFER  | one word per cycle, word 0 first
// DONE  | ready pulse
// HOLD  | waits for both enables low so a request is served once
// ---------------------------------------------------------------------------
module offchip_mem_responder #(
    parameter int LINE_BYTES = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int LAT        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    offchip_mem_read_en,
    input  logic                    offchip_mem_write_en,
    input  logic [31:0]             offchip_mem_addr,
    input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
    output logic [LINE_BYTES*8-1:0] offchip_mem_data,
`ifdef OFFCHIP_MEM_RANGE_CHK_EN
    output logic                    offchip_mem_err,
`endif
    output logic                    offchip_mem_ready,
    output logic                    offchip_mem_read_busy,
    output logic                    offchip_mem_write_busy
);

    localparam int WORDS = LINE_BYTES / 4;
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [3:0]    WAIT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [AW-1:0] LINE_MASK = AW'(WORDS - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        XFER = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    is_wr_q, is_wr_d;
    logic                    oor_q, oor_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [WORDS-1:0][31:0]  wdata_q, wdata_d;
    logic [WORDS-1:0][31:0]  data_q, data_d;

    logic [31:0]             mem [MEM_WORDS];
    logic [AW-1:0]           mem_idx;
    logic                    mem_we;
    logic                    req_oor;

    // Address bits that never select a word: byte offset always, and the
    // bits above the store only matter for the range check.
    logic                    unused_addr;

`ifdef OFFCHIP_MEM_RANGE_CHK_EN
    assign req_oor     = |offchip_mem_addr[31:AW+2];
    assign unused_addr = ^offchip_mem_addr[1:0];
`else
    assign req_oor     = 1'b0;
    assign unused_addr = ^{offchip_mem_addr[31:AW+2], offchip_mem_addr[1:0]};
`endif

    // Line base is word-aligned to WORDS, so base+i is just the beat number
    // dropped into the low word-select bits; the upper bits wrap modulo
    // MEM_WORDS by truncation.
    assign mem_idx = (addr_q & ~LINE_MASK) | AW'(beat_q);
    assign mem_we  = (state_q == XFER) && is_wr_q && !oor_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        is_wr_d = is_wr_q;
        oor_d   = oor_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (offchip_mem_write_en || offchip_mem_read_en) begin
                    is_wr_d = offchip_mem_write_en;
                    addr_d  = offchip_mem_addr[AW+1:2];
                    wdata_d = offchip_mem_wdata;
                    oor_d   = req_oor;
                    beat_d  = '0;
                    cnt_d   = WAIT_LOAD;
                    state_d = (LAT > 0) ? WAIT : XFER;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XFER: begin
                if (!is_wr_q) begin
                    data_d[beat_q] = oor_q ? 32'd0 : mem[mem_idx];
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!offchip_mem_read_en && !offchip_mem_write_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            is_wr_q <= is_wr_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Backing store is never cleared; a reset only stops the beat in flight.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_idx] <= wdata_q[beat_q];
        end
    end

    assign offchip_mem_data       = data_q;
    assign offchip_mem_ready      = (state_q == DONE);
    assign offchip_mem_read_busy  = ((state_q == WAIT) || (state_q == XFER)) && !is_wr_q;
    assign offchip_mem_write_busy = ((state_q == WAIT) || (state_q == XFER)) && is_wr_q;
`ifdef OFFCHIP_MEM_RANGE_CHK_EN
    assign offchip_mem_err        = (state_q == DONE) && oor_q;
`endif

endmodule
